// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A free-running divider splits time into digit slots. A 2-bit pointer
// selects the digit for each slot in the order unit, tens, hund, thou.
// Each slot starts with DEAD_CYC cycles in which all digits are off, to
// suppress ghosting. New BCD digits arrive with a data_valid pulse and are
// held as pending. They become visible only at a frame boundary (pointer
// wrapping 3->0), so a frame is never drawn from a mix of old and new digits.
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   data_valid        : one-cycle strobe qualifying the four digit inputs
//   thou/hund/tens/unit_data [3:0] : BCD digits
//   seg_sel  [3:0]    : active-low one-hot digit enable (bit0 = unit)
//   seg_data [7:0]    : active-low segments {dp,g,f,e,d,c,b,a}
//   upd_done          : one-cycle pulse when new digits become displayed
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEAD_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_valid,
  input  logic [3:0] thou_data,
  input  logic [3:0] hund_data,
  input  logic [3:0] tens_data,
  input  logic [3:0] unit_data,
  output logic [3:0] seg_sel,
  output logic [7:0] seg_data,
  output logic       upd_done
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  typedef logic [DIV_W-1:0] div_t;
  localparam div_t LAST_V = div_t'(SCAN_DIV - 1);
  localparam div_t DEAD_V = div_t'(DEAD_CYC);

  // Four BCD digits; index 0 = unit, 3 = thou.
  typedef logic [3:0][3:0] digits_t;

  function automatic logic [7:0] seg_code(input logic [3:0] v);
    logic [7:0] c;
    case (v)
      4'd0:    c = 8'hC0;
      4'd1:    c = 8'hF9;
      4'd2:    c = 8'hA4;
      4'd3:    c = 8'hB0;
      4'd4:    c = 8'h99;
      4'd5:    c = 8'h92;
      4'd6:    c = 8'h82;
      4'd7:    c = 8'hF8;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h90;
      default: c = 8'hBF;  // not BCD: show "-"
    endcase
    return c;
  endfunction

  div_t       div_cnt_q, div_cnt_d;
  logic [1:0] ptr_q, ptr_d;
  logic       pend_q, pend_d;
  digits_t    pend_dig_q, pend_dig_d;
  digits_t    disp_q, disp_d;
  logic [3:0] seg_sel_q, seg_sel_d;
  logic [7:0] seg_data_q, seg_data_d;
  logic       upd_done_q, upd_done_d;

  logic       tick;
  logic       wrap;
  digits_t    live;
  logic [3:0] blank;

  assign live = {thou_data, hund_data, tens_data, unit_data};
  assign tick = (div_cnt_q == LAST_V);
  assign wrap = tick && (ptr_q == 2'd3);

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
    ptr_d      = tick ? ptr_q + 2'd1 : ptr_q;
    pend_d     = pend_q;
    pend_dig_d = pend_dig_q;
    disp_d     = disp_q;
    upd_done_d = 1'b0;

    if (wrap) begin
      // Frame boundary: a strobe on this very cycle takes priority over the
      // pending set, since it is the newer data.
      if (data_valid) begin
        disp_d = live;
      end else if (pend_q) begin
        disp_d = pend_dig_q;
      end
      upd_done_d = data_valid | pend_q;
      pend_d     = 1'b0;
    end else if (data_valid) begin
      pend_dig_d = live;
      pend_d     = 1'b1;
    end

    // Leading-zero blanking cascades down from thou; unit is never blanked.
    // Values above 9 are non-zero, so they stop the cascade.
    blank[3] = (disp_d[3] == 4'd0);
    blank[2] = blank[3] && (disp_d[2] == 4'd0);
    blank[1] = blank[2] && (disp_d[1] == 4'd0);
    blank[0] = 1'b0;

    // Outputs are registered from next-state values so the pins line up
    // exactly with the divider count and pointer they belong to.
    if (div_cnt_d < DEAD_V) begin
      seg_sel_d = 4'hF;
    end else begin
      seg_sel_d = ~(4'b0001 << ptr_d);
    end
    seg_data_d = blank[ptr_d] ? 8'hFF : seg_code(disp_d[ptr_d]);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: the digit storage is reset too; after reset it must read as zero so
  // the display shows "0" and stale data cannot be committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      ptr_q      <= 2'd0;
      pend_q     <= 1'b0;
      pend_dig_q <= '0;
      disp_q     <= '0;
      seg_sel_q  <= 4'hF;
      seg_data_q <= 8'hFF;
      upd_done_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      ptr_q      <= ptr_d;
      pend_q     <= pend_d;
      pend_dig_q <= pend_dig_d;
      disp_q     <= disp_d;
      seg_sel_q  <= seg_sel_d;
      seg_data_q <= seg_data_d;
      upd_done_q <= upd_done_d;
    end
  end

  assign seg_sel  = seg_sel_q;
  assign seg_data = seg_data_q;
  assign upd_done = upd_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver with SCAN_DIV = 4 and DEAD_CYC = 1.
// The reference model counts clock edges since reset release. It derives the
// slot position, pointer and frame boundary arithmetically from that count,
// and keeps the pending and displayed digits as plain arrays.
module tb_seg_scan_driver;

  localparam int SD = 4;
  localparam int DC = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_valid = 1'b0;
  logic [3:0] thou_data = '0, hund_data = '0, tens_data = '0, unit_data = '0;
  logic [3:0] seg_sel;
  logic [7:0] seg_data;
  logic       upd_done;

  seg_scan_driver #(.SCAN_DIV(SD), .DEAD_CYC(DC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_valid (data_valid),
    .thou_data  (thou_data),
    .hund_data  (hund_data),
    .tens_data  (tens_data),
    .unit_data  (unit_data),
    .seg_sel    (seg_sel),
    .seg_data   (seg_data),
    .upd_done   (upd_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state. Digit index 0 = unit, 3 = thou.
  int         n;
  bit         m_pend;
  logic [3:0] m_pendv[4];
  logic [3:0] m_disp[4];
  bit         m_upd;
  int         upd_seen;
  logic [7:0] code_tab[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  function automatic void model_reset();
    n = 0; m_pend = 0; m_upd = 0;
    for (int i = 0; i < 4; i++) begin m_pendv[i] = '0; m_disp[i] = '0; end
  endfunction

  function automatic logic [3:0] exp_sel();
    int ptr = (n / SD) % 4;
    if ((n % SD) < DC) return 4'hF;
    return ~(4'(1) << ptr);
  endfunction

  function automatic logic [7:0] exp_data();
    int  ptr = (n / SD) % 4;
    bit  all_zero = 1;
    if (n == 0) return 8'hFF;  // reset value still held before the first edge
    for (int j = 3; j >= ptr; j--) if (m_disp[j] != 0) all_zero = 0;
    if (ptr > 0 && all_zero) return 8'hFF;
    if (m_disp[ptr] > 9) return 8'hBF;
    return code_tab[m_disp[ptr]];
  endfunction

  // One clock cycle with the given strobe/digits, then the model advances.
  task automatic cycle(input bit dv, input logic [3:0] t, h, te, u);
    logic [3:0] d[4];
    bit         wrap;
    d = '{u, te, h, t};
    data_valid = dv; thou_data = t; hund_data = h; tens_data = te; unit_data = u;
    @(posedge clk);
    wrap  = (n % (4 * SD)) == (4 * SD - 1);
    m_upd = 0;
    if (wrap) begin
      if (dv) begin m_disp = d; m_upd = 1; end
      else if (m_pend) begin m_disp = m_pendv; m_upd = 1; end
      m_pend = 0;
    end else if (dv) begin
      m_pendv = d; m_pend = 1;
    end
    n++;
    #1;
    data_valid = 1'b0;
    if (upd_done === 1'b1) upd_seen++;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    checks++;
    if ({seg_sel, seg_data, upd_done} !== {4'hF, 8'hFF, 1'b0}) begin
      failures++;
      $display("FAIL reset_hold: got sel=%h data=%h upd=%b want F FF 0", seg_sel, seg_data, upd_done);
    end
    @(posedge clk); #3 rst_n = 1'b1;
    upd_seen = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(0, 0, 0, 0, 0);
      checks++;
      if ({seg_sel, seg_data, upd_done} !== {exp_sel(), exp_data(), m_upd}) begin
        failures++;
        $display("FAIL idle n=%0d: got %h/%h/%b want %h/%h/%b", n, seg_sel, seg_data, upd_done, exp_sel(), exp_data(), m_upd);
      end
    end
    checks++;
    if (upd_seen != 0) begin failures++; $display("FAIL idle_upd: got %0d pulses want 0", upd_seen); end
  endtask

  task automatic test_update_1234();
    bit sent = 0;
    upd_seen = 0;
    for (int i = 0; i < 48; i++) begin
      bit dv = !sent && (n % 16 == 6);
      if (dv) sent = 1;
      cycle(dv, 1, 2, 3, 4);
      checks++;
      if ({seg_sel, seg_data, upd_done} !== {exp_sel(), exp_data(), m_upd}) begin
        failures++;
        $display("FAIL upd1234 n=%0d: got %h/%h/%b want %h/%h/%b", n, seg_sel, seg_data, upd_done, exp_sel(), exp_data(), m_upd);
      end
    end
    checks++;
    if (upd_seen != 1) begin failures++; $display("FAIL upd1234_pulses: got %0d want 1", upd_seen); end
  endtask

  task automatic test_blanking();
    int sent = 0;
    upd_seen = 0;
    for (int i = 0; i < 80; i++) begin
      bit dv = (n % 16 == 3) && (sent < 2) && (i >= sent * 32);
      if (dv) begin
        if (sent == 0) cycle(1, 0, 0, 0, 7); else cycle(1, 0, 1, 0, 0);
        sent++;
      end else begin
        cycle(0, 0, 0, 0, 0);
      end
      checks++;
      if ({seg_sel, seg_data, upd_done} !== {exp_sel(), exp_data(), m_upd}) begin
        failures++;
        $display("FAIL blank n=%0d: got %h/%h/%b want %h/%h/%b", n, seg_sel, seg_data, upd_done, exp_sel(), exp_data(), m_upd);
      end
    end
    checks++;
    if (upd_seen != 2) begin failures++; $display("FAIL blank_pulses: got %0d want 2", upd_seen); end
  endtask

  task automatic test_last_wins();
    int sent = 0;
    upd_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (sent == 0 && n % 16 == 2) begin cycle(1, 5, 5, 5, 5); sent = 1; end
      else if (sent == 1 && n % 16 == 9) begin cycle(1, 0, 0, 4, 2); sent = 2; end
      else cycle(0, 9, 9, 9, 9);
      checks++;
      if ({seg_sel, seg_data, upd_done} !== {exp_sel(), exp_data(), m_upd}) begin
        failures++;
        $display("FAIL lastwins n=%0d: got %h/%h/%b want %h/%h/%b", n, seg_sel, seg_data, upd_done, exp_sel(), exp_data(), m_upd);
      end
    end
    checks++;
    if (upd_seen != 1) begin failures++; $display("FAIL lastwins_pulses: got %0d want 1", upd_seen); end
  endtask

  task automatic test_wrap_tick();
    int sent = 0;
    upd_seen = 0;
    for (int i = 0; i < 56; i++) begin
      if (n % 16 == 15 && sent == 0) begin cycle(1, 9, 9, 9, 9); sent = 1; end
      else if (n % 16 == 15 && sent == 1 && i > 20) begin cycle(1, 0, 0, 0, 4'hA); sent = 2; end
      else cycle(0, 0, 0, 0, 0);
      checks++;
      if ({seg_sel, seg_data, upd_done} !== {exp_sel(), exp_data(), m_upd}) begin
        failures++;
        $display("FAIL wraptick n=%0d: got %h/%h/%b want %h/%h/%b", n, seg_sel, seg_data, upd_done, exp_sel(), exp_data(), m_upd);
      end
    end
    checks++;
    if (upd_seen != 2) begin failures++; $display("FAIL wraptick_pulses: got %0d want 2", upd_seen); end
  endtask

  task automatic test_reset_pending();
    bit sent = 0;
    while (!(sent && n % 16 == 9)) begin
      if (!sent && n % 16 == 4) begin cycle(1, 1, 2, 3, 4); sent = 1; end
      else cycle(0, 0, 0, 0, 0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({seg_sel, seg_data, upd_done} !== {4'hF, 8'hFF, 1'b0}) begin
      failures++;
      $display("FAIL async_reset: got sel=%h data=%h upd=%b want F FF 0", seg_sel, seg_data, upd_done);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    upd_seen = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(0, 0, 0, 0, 0);
      checks++;
      if ({seg_sel, seg_data, upd_done} !== {exp_sel(), exp_data(), m_upd}) begin
        failures++;
        $display("FAIL after_reset n=%0d: got %h/%h/%b want %h/%h/%b", n, seg_sel, seg_data, upd_done, exp_sel(), exp_data(), m_upd);
      end
    end
    checks++;
    if (upd_seen != 0) begin failures++; $display("FAIL reset_discard: got %0d pulses want 0", upd_seen); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bit dv = ($urandom_range(0, 9) == 0);
      cycle(dv, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
            4'($urandom_range(0, 11)), 4'($urandom_range(0, 15)));
      checks++;
      if ({seg_sel, seg_data, upd_done} !== {exp_sel(), exp_data(), m_upd}) begin
        failures++;
        $display("FAIL random n=%0d: got %h/%h/%b want %h/%h/%b", n, seg_sel, seg_data, upd_done, exp_sel(), exp_data(), m_upd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_update_1234();
    test_blanking();
    test_last_wins();
    test_wrap_tick();
    test_reset_pending();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clock cycles per digit slot; legal range 4 or more.
REQ-002 SHALL have parameter DEAD_CYC, default 2: cycles at the start of each slot with all digits off; legal range 0 to SCAN_DIV-1.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port data_valid, input, 1 bit: one-cycle pulse (the converter's tran_done) qualifying the four digit inputs.
REQ-006 SHALL have ports thou_data, hund_data, tens_data, unit_data, input, 4 bits each: BCD digits from the binary-to-BCD stage.
REQ-007 SHALL have port seg_sel, output, 4 bits: active-low one-hot digit enable; bit 0 = unit, bit 1 = tens, bit 2 = hund, bit 3 = thou.
REQ-008 SHALL have port seg_data, output, 8 bits: active-low segments {dp,g,f,e,d,c,b,a}.
REQ-009 SHALL have port upd_done, output, 1 bit: one-cycle pulse when new digits become the displayed set.

Function
REQ-010 SHALL run divider div_cnt from 0 to SCAN_DIV-1 and wrap to 0; tick = (div_cnt == SCAN_DIV-1).
REQ-011 SHALL advance digit pointer ptr 0->1->2->3->0 on each tick.
REQ-012 SHALL register seg_sel/seg_data: for div_cnt < DEAD_CYC seg_sel = 4'b1111; otherwise seg_sel drives bit ptr low and all other bits high.
REQ-013 SHALL keep seg_data at the code of the pointed digit during the whole slot, dp always off (bit7 = 1).
REQ-014 SHALL use these codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex); BCD value >9 = BF (g only, "-").
REQ-015 SHALL blank leading zeros (seg_data = FF): thou blanked if thou==0; hund if thou==0 and hund==0; tens if thou, hund, tens all 0; unit never blanked; codes >9 count as non-zero.
REQ-016 SHALL capture the four inputs into pending registers and set pend on data_valid; a later data_valid before commit overwrites pending (last wins).
REQ-017 SHALL commit pending to display registers only on the tick where ptr wraps 3->0 and pend=1, then clear pend and pulse upd_done in the following cycle; no tearing mid-frame.
REQ-018 SHALL, when data_valid coincides with that commit tick, commit the live inputs directly, leave pend cleared, and pulse upd_done.
REQ-019 SHALL make committed digits appear from the first unit slot after the commit; latency from data_valid is 1 to 4*SCAN_DIV+1 cycles.
REQ-020 SHALL ignore data_valid = 0 on the inputs; display holds indefinitely without new data.

Reset
REQ-021 SHALL, while rst_n = 0, force seg_sel = 4'b1111, seg_data = 8'hFF, upd_done = 0, div_cnt = 0, ptr = 0, pend = 0, and pending/display registers = 0.
REQ-022 SHALL, after reset release, start at slot ptr = 0 with display value 0: unit shows C0 and the other digits are blanked.
REQ-023 SHALL, on reset mid-frame or with pend set, discard pending data; no upd_done follows.

Verification (SCAN_DIV = 4, DEAD_CYC = 1)
REQ-024 Reset release, no data -> per 4-cycle slot: 1 cycle with seg_sel = F, then 3 cycles with seg_sel = E and seg_data = C0; slots 1-3 show seg_data = FF.
REQ-025 data_valid with 1,2,3,4 (thou..unit) mid-frame -> no change until the 3->0 wrap; upd_done pulses once; then slots show 99, B0, A4, F9.
REQ-026 Digits 0,0,0,7 -> thou, hund, tens = FF, unit = F8; digits 0,1,0,0 -> thou = FF, hund = F9, tens = C0, unit = C0.
REQ-027 Two data_valid pulses in one frame (5555, then 0042) -> only 0042 is displayed; single upd_done.
REQ-028 data_valid exactly on the wrap tick with 9,9,9,9 -> next frame shows 90 on all digits, upd_done = 1 once; unit digit = 4'hA -> BF.
REQ-029 rst_n low while pend = 1 -> outputs go to F/FF immediately (asynchronously); after release, display shows 0 and no upd_done.
